// File: rtl/sd_relu_conv.sv
// Online signed-digit (MSB-first, radix-2) to binary converter with ReLU output.
// Early termination on a negative leading digit is enabled by SD_RELU_EARLY_TERM_EN.
module sd_relu_conv #(
    parameter int N     = 16,
    parameter int DELTA = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         z_p,
    input  logic         z_n,
    output logic [N-1:0] relu_q,
    output logic         done,
    output logic         neg,
    output logic         term,
    output logic         busy
);
    localparam int CMAX = (N > DELTA) ? N : DELTA;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT, CONV, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    q_q, q_d;
    logic [N:0]    qm_q, qm_d;
    logic [N-1:0]  relu_val_q, relu_val_d;
    logic          neg_q, neg_d;
    logic          seen_q, seen_d;
    logic          done_q, done_d;
    logic          term_q, term_d;
    logic          d_pos, d_neg;

    // (1,1) cancels to zero, same as (0,0)
    assign d_pos = z_p & ~z_n;
    assign d_neg = z_n & ~z_p;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        q_d        = q_q;
        qm_d       = qm_q;
        relu_val_d = relu_val_q;
        neg_d      = neg_q;
        seen_d     = seen_q;
        done_d     = 1'b0;
        term_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d      = '0;
                    q_d        = '0;
                    qm_d       = '1;
                    neg_d      = 1'b0;
                    seen_d     = 1'b0;
                    relu_val_d = '0;
                    state_d    = (DELTA == 0) ? CONV : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CW'(DELTA - 1)) begin
                    cnt_d   = '0;
                    state_d = CONV;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CONV: begin
                if (d_pos) begin
                    q_d  = {q_q[N-1:0], 1'b1};
                    qm_d = {q_q[N-1:0], 1'b0};
                end else if (d_neg) begin
                    q_d  = {qm_q[N-1:0], 1'b1};
                    qm_d = {qm_q[N-1:0], 1'b0};
                end else begin
                    q_d  = {q_q[N-1:0], 1'b0};
                    qm_d = {qm_q[N-1:0], 1'b1};
                end
                // The leading nonzero digit fixes the sign of the whole number
                if (!seen_q && (d_pos || d_neg)) begin
                    seen_d = 1'b1;
                    neg_d  = d_neg;
                end
`ifdef SD_RELU_EARLY_TERM_EN
                if (!seen_q && d_neg) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    term_d     = 1'b1;
                    relu_val_d = '0;
                end else
`endif
                if (cnt_q == CW'(N - 1)) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    relu_val_d = neg_d ? '0 : q_d[N-1:0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            q_q        <= '0;
            qm_q       <= '1;
            relu_val_q <= '0;
            neg_q      <= 1'b0;
            seen_q     <= 1'b0;
            done_q     <= 1'b0;
            term_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            q_q        <= q_d;
            qm_q       <= qm_d;
            relu_val_q <= relu_val_d;
            neg_q      <= neg_d;
            seen_q     <= seen_d;
            done_q     <= done_d;
            term_q     <= term_d;
        end
    end

    assign relu_q = relu_val_q;
    assign done   = done_q;
    assign neg    = neg_q;
    assign term   = term_q;
    assign busy   = (state_q == WAIT) || (state_q == CONV);
endmodule

// File: tb/tb_sd_relu_conv.sv
// Scoreboard bench for sd_relu_conv (N=8, DELTA=3): arithmetic reference model,
// random and directed digit streams, ignored restarts and mid-conversion reset.
module tb_sd_relu_conv;
    localparam int N     = 8;
    localparam int DELTA = 3;

    logic         clk = 1'b0;
    logic         rst, start, z_p, z_n;
    logic [N-1:0] relu_q;
    logic         done, neg, term, busy;

    sd_relu_conv #(.N(N), .DELTA(DELTA)) dut (
        .clk(clk), .rst(rst), .start(start), .z_p(z_p), .z_n(z_n),
        .relu_q(relu_q), .done(done), .neg(neg), .term(term), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int relu;
        int ng;
        int tm;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   hold_rel = 0;
    int   hold_neg = 0;
    bit   hold_valid = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every done pulse against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("relu_q", int'(relu_q), e.relu);
                chk("neg", int'(neg), e.ng);
                chk("term", int'(term), e.tm);
                chk("done_cycle", cyc, e.cyc);
                chk("busy_in_done", int'(busy), 0);
                $display("done @%0d relu_q=%02h neg=%0d term=%0d", cyc, relu_q, neg, term);
                hold_rel   = e.relu;
                hold_neg   = e.ng;
                hold_valid = 1'b1;
            end
        end else if (!busy && hold_valid && !rst) begin
            chk("hold_relu_q", int'(relu_q), hold_rel);
            chk("hold_neg", int'(neg), hold_neg);
            chk("idle_term", int'(term), 0);
        end
    end

    // One conversion: p[j]/nn[j] are the rails of digit j (j=0 is the MSB digit)
    task automatic run(input logic [N-1:0] p, input logic [N-1:0] nn,
                       input bit dup, input int rst_at);
        int   s;
        int   val = 0;
        int   fnz = -1;
        int   ng = 0;
        int   d;
        int   j;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            d = (p[i] && !nn[i]) ? 1 : ((nn[i] && !p[i]) ? -1 : 0);
            val += d * (1 << (N - 1 - i));
            if (d != 0 && fnz < 0) begin
                fnz = i;
                ng  = (d < 0) ? 1 : 0;
            end
        end
        e.relu = (val < 0) ? 0 : val;
        e.ng   = ng;
        e.tm   = 0;
        @(negedge clk);
        s     = cyc;
        e.cyc = s + DELTA + N + 1;
`ifdef SD_RELU_EARLY_TERM_EN
        if (ng == 1) begin
            e.tm   = 1;
            e.relu = 0;
            e.cyc  = s + DELTA + 2 + fnz;
        end
`endif
        if (rst_at < 0) sb.push_back(e);
        $display("start @%0d p=%02h n=%02h dup=%0d rst_at=%0d exp relu=%02h neg=%0d term=%0d",
                 s, p, nn, dup, rst_at, e.relu, e.ng, e.tm);
        start = 1'b1;
        {z_p, z_n} = 2'($urandom_range(0, 3));
        for (int k = 1; k <= DELTA + N + 1; k++) begin
            @(negedge clk);
            if (k == 1) chk("busy_after_start", int'(busy), 1);
            if (rst_at >= 0 && k == rst_at + 1) begin
                chk("rst_done", int'(done), 0);
                chk("rst_relu_q", int'(relu_q), 0);
                chk("rst_neg", int'(neg), 0);
                chk("rst_term", int'(term), 0);
                chk("rst_busy", int'(busy), 0);
                rst = 1'b0;
                break;
            end
            start = dup && (k == 5);
            rst   = (k == rst_at);
            if (rst) begin
                hold_rel = 0;
                hold_neg = 0;
            end
            j = k - DELTA - 1;
            if (j >= 0 && j < N) begin
                z_p = p[j];
                z_n = nn[j];
            end else begin
                {z_p, z_n} = 2'($urandom_range(0, 3));
            end
        end
        start = 1'b0;
    endtask

    initial begin
        logic [N-1:0] rp, rn;
        rst = 1'b1; start = 1'b0; z_p = 1'b0; z_n = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("reset_relu_q", int'(relu_q), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_neg", int'(neg), 0);
        chk("reset_term", int'(term), 0);
        chk("reset_busy", int'(busy), 0);
        start = 1'b0;
        rst   = 1'b0;
        hold_valid = 1'b1;

        run(8'b0000_0010, 8'b0000_1000, 1'b0, -1);  // 0,+1,0,-1,0,0,0,0
        run(8'hFF, 8'h00, 1'b0, -1);                // +1 x8
        run(8'h00, 8'h00, 1'b0, -1);                // 0 x8
        run(8'b1111_1000, 8'b0000_0100, 1'b0, -1);  // 0,0,-1,+1 x5
        run(8'b1000_0001, 8'b0000_0110, 1'b0, -1);  // +1,-1,-1,0,0,0,0,+1
        run(8'hFF, 8'hFF, 1'b0, -1);                // (1,1) everywhere
        run(8'b0000_0010, 8'b0000_1000, 1'b1, -1);  // restart at cycle 5 ignored
        run(8'hFF, 8'h00, 1'b0, 8);                 // reset mid-conversion
        run(8'h01, 8'h00, 1'b0, -1);                // +1 leading, recovers after reset
        for (int t = 0; t < 40; t++) begin
            rp = 8'($urandom);
            rn = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run(rp, rn, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 12)) : -1);
        end
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
